// File: rtl/reg_scoreboard_pkg.sv
// Shared constants for the register scoreboard: default geometry, bus slice
// widths and a sizing helper for per-register lane counts.
package reg_scoreboard_pkg;

   localparam int unsigned NREGS_DEF = 32;
   localparam int unsigned AW_DEF    = 5;
   localparam int unsigned NRD_DEF   = 2;
   localparam int unsigned NWR_DEF   = 2;
   localparam int unsigned CW_DEF    = 3;

   // Packed address buses are NRD or NWR slices of AW bits each.
   localparam int unsigned ADDR_SLICE_W = AW_DEF;
   localparam int unsigned SRC_BUS_W    = NRD_DEF * AW_DEF;
   localparam int unsigned DST_BUS_W    = NWR_DEF * AW_DEF;

   // Bits needed to count how many of n lanes hit one register in a cycle.
   function automatic int unsigned lane_cnt_w(input int unsigned n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/reg_scoreboard_if.sv
// Issue/retire/status bundle between the decoder (master) and the scoreboard (slave).
interface reg_scoreboard_if
   import reg_scoreboard_pkg::*;
#(
   parameter int unsigned NREGS = NREGS_DEF,
   parameter int unsigned AW    = AW_DEF,
   parameter int unsigned NRD   = NRD_DEF,
   parameter int unsigned NWR   = NWR_DEF,
   parameter int unsigned CW    = CW_DEF
) ();

   logic                iss_valid;
   logic                iss_ready;
   logic [NRD*AW-1:0]   src_addr;
   logic [NRD-1:0]      src_en;
   logic [NWR*AW-1:0]   dst_addr;
   logic [NWR-1:0]      dst_en;
   logic [NWR*AW-1:0]   ret_addr;
   logic [NWR-1:0]      ret_en;
   logic                flush;
   logic [NREGS-1:0]    busy;
   logic [CW+AW-1:0]    inflight;
   logic                ovf_err;

   modport master (
      output iss_valid, src_addr, src_en, dst_addr, dst_en, ret_addr, ret_en, flush,
      input  iss_ready, busy, inflight, ovf_err
   );

   modport slave (
      input  iss_valid, src_addr, src_en, dst_addr, dst_en, ret_addr, ret_en, flush,
      output iss_ready, busy, inflight, ovf_err
   );

endinterface

// File: rtl/reg_scoreboard_sb_counter.sv
// One register's pending-write counter: applies a net +inc/-dec per cycle,
// clamps to [0, 2^CW-1] and flags any clamp as an error.
module sb_counter #(
   parameter int unsigned CW = 3,
   parameter int unsigned DW = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr_i,
   input  logic [DW-1:0] inc_i,
   input  logic [DW-1:0] dec_i,
   output logic [CW-1:0] cnt_o,
   output logic          err_o
);

   localparam int unsigned SW = ((CW > DW) ? CW : DW) + 2;
   localparam logic [SW-1:0] MAX = SW'((1 << CW) - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic [SW-1:0] sum;
   logic          under, over;

   always_comb begin
      sum   = SW'(cnt_q) + SW'(inc_i) - SW'(dec_i);
      under = sum[SW-1];
      over  = !under && (sum > MAX);
      cnt_d = under ? '0 : (over ? MAX[CW-1:0] : sum[CW-1:0]);
   end

   assign err_o = !clr_i && (under || over);
   assign cnt_o = cnt_q;

   // NOTE: non-blocking so every counter updates from the same pre-edge state.
   always_ff @(posedge clk) begin
      if (!rst)       cnt_q <= '0;
      else if (clr_i) cnt_q <= '0;
      else            cnt_q <= cnt_d;
   end

endmodule

// File: rtl/reg_scoreboard.sv
// Register scoreboard: blocks issue on RAW/WAW hazards and tracks how many
// writes are pending per architectural register.
module reg_scoreboard
   import reg_scoreboard_pkg::*;
#(
   parameter int unsigned NREGS = NREGS_DEF,
   parameter int unsigned AW    = AW_DEF,
   parameter int unsigned NRD   = NRD_DEF,
   parameter int unsigned NWR   = NWR_DEF,
   parameter int unsigned CW    = CW_DEF
) (
   input  logic             clk,
   input  logic             rst,
   reg_scoreboard_if.slave  sb
);

   localparam int unsigned DW = lane_cnt_w(NWR);

   logic [CW-1:0]    cnt     [NREGS];
   logic [DW-1:0]    inc_cnt [NREGS];
   logic [DW-1:0]    dec_cnt [NREGS];
   logic [NREGS-1:0] busy_vec;
   logic [NREGS-1:0] err_vec;
   logic             hazard, fire;
   logic [CW+AW-1:0] inflight_q, inflight_d;
   logic             ovf_err_q;

   // Out-of-range addresses never match any r below, so they neither block nor count.
   always_comb begin
      hazard = 1'b0;
      for (int r = 0; r < NREGS; r++) begin
         for (int i = 0; i < NRD; i++)
            if (sb.src_en[i] && sb.src_addr[i*AW +: AW] == AW'(r) && busy_vec[r]) hazard = 1'b1;
         for (int w = 0; w < NWR; w++)
            if (sb.dst_en[w] && sb.dst_addr[w*AW +: AW] == AW'(r) && busy_vec[r]) hazard = 1'b1;
      end
   end

   assign sb.iss_ready = rst && !sb.flush && !hazard;
   assign fire         = sb.iss_valid && sb.iss_ready;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      for (int r = 0; r < NREGS; r++) begin
         inc_cnt[r] = '0;
         dec_cnt[r] = '0;
         for (int w = 0; w < NWR; w++) begin
            if (fire && sb.dst_en[w] && sb.dst_addr[w*AW +: AW] == AW'(r)) inc_cnt[r] = inc_cnt[r] + DW'(1);
            if (sb.ret_en[w] && sb.ret_addr[w*AW +: AW] == AW'(r))         dec_cnt[r] = dec_cnt[r] + DW'(1);
         end
      end
   end

   for (genvar r = 0; r < NREGS; r++) begin : g_cnt
      sb_counter #(.CW(CW), .DW(DW)) u_cnt (
         .clk   (clk),
         .rst   (rst),
         .clr_i (sb.flush),
         .inc_i (inc_cnt[r]),
         .dec_i (dec_cnt[r]),
         .cnt_o (cnt[r]),
         .err_o (err_vec[r])
      );
      assign busy_vec[r] = |cnt[r];
   end

   always_comb begin
      inflight_d = '0;
      for (int r = 0; r < NREGS; r++) inflight_d = inflight_d + (CW+AW)'(cnt[r]);
   end

   // NOTE: the counters are flops, not a RAM, so they are reset and busy is valid from the first cycle.
   always_ff @(posedge clk) begin
      if (!rst) begin
         inflight_q <= '0;
         ovf_err_q  <= 1'b0;
      end else begin
         inflight_q <= inflight_d;
         if (|err_vec) ovf_err_q <= 1'b1;
      end
   end

   assign sb.busy     = busy_vec;
   assign sb.inflight = inflight_q;
   assign sb.ovf_err  = ovf_err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed and random checks of reg_scoreboard against an array-based model of
// the pending-write rules, plus a CW=1 instance for counter saturation.
module tb_reg_scoreboard;

   localparam int TN  = 12;
   localparam int TAW = 4;
   localparam int TCW = 2;
   localparam int CMAX = (1 << TCW) - 1;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic rst2 = 1'b0;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   reg_scoreboard_if #(.NREGS(TN), .AW(TAW), .NRD(2), .NWR(2), .CW(TCW)) sif ();
   reg_scoreboard #(.NREGS(TN), .AW(TAW), .NRD(2), .NWR(2), .CW(TCW)) u_dut (
      .clk (clk), .rst (rst), .sb (sif.slave)
   );

   reg_scoreboard_if #(.NREGS(3), .AW(2), .NRD(1), .NWR(2), .CW(1)) sif2 ();
   reg_scoreboard #(.NREGS(3), .AW(2), .NRD(1), .NWR(2), .CW(1)) u_dut2 (
      .clk (clk), .rst (rst2), .sb (sif2.slave)
   );

   // Reference model: plain pending-write counts per register.
   int m_cnt [TN];
   bit m_err;
   int m_infl;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic bit pending(input int a);
      return (a < TN) && (m_cnt[a] != 0);
   endfunction

   // One clock cycle: drive after negedge, check ready, advance model, check state after posedge.
   task automatic step(input bit rstn, input bit fl, input bit v,
                       input int s0, input int s1, input bit [1:0] sen,
                       input int d0, input int d1, input bit [1:0] den,
                       input int r0, input int r1, input bit [1:0] ren);
      bit exp_ready, fire;
      int dlt [TN];
      int sum, n, da[2], ra[2];
      logic [TN-1:0] exp_busy;
      rst = rstn;
      sif.flush     = fl;
      sif.iss_valid = v;
      sif.src_addr  = {TAW'(s1), TAW'(s0)};
      sif.src_en    = sen;
      sif.dst_addr  = {TAW'(d1), TAW'(d0)};
      sif.dst_en    = den;
      sif.ret_addr  = {TAW'(r1), TAW'(r0)};
      sif.ret_en    = ren;
      #1;
      exp_ready = rstn && !fl &&
                  !((sen[0] && pending(s0)) || (sen[1] && pending(s1)) ||
                    (den[0] && pending(d0)) || (den[1] && pending(d1)));
      check("iss_ready", sif.iss_ready, exp_ready);
      fire = v && exp_ready;
      sum = 0;
      foreach (m_cnt[r]) begin sum += m_cnt[r]; dlt[r] = 0; end
      da[0] = d0; da[1] = d1; ra[0] = r0; ra[1] = r1;
      if (!rstn) begin
         foreach (m_cnt[r]) m_cnt[r] = 0;
         m_err = 0;
         m_infl = 0;
      end else begin
         m_infl = sum;
         if (fl) begin
            foreach (m_cnt[r]) m_cnt[r] = 0;
         end else begin
            for (int i = 0; i < 2; i++) begin
               if (fire && den[i] && da[i] < TN) dlt[da[i]]++;
               if (ren[i] && ra[i] < TN) dlt[ra[i]]--;
            end
            foreach (m_cnt[r]) begin
               n = m_cnt[r] + dlt[r];
               if (n > CMAX) begin n = CMAX; m_err = 1; end
               if (n < 0)    begin n = 0;    m_err = 1; end
               m_cnt[r] = n;
            end
         end
      end
      foreach (m_cnt[r]) exp_busy[r] = (m_cnt[r] != 0);
      @(posedge clk);
      #1;
      check("busy", sif.busy, exp_busy);
      check("inflight", sif.inflight, m_infl);
      check("ovf_err", sif.ovf_err, m_err);
      @(negedge clk);
   endtask

   task automatic idle();
      step(1, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 2'b00);
   endtask

   initial begin
      sif.iss_valid = 0; sif.flush = 0; sif.src_addr = '0; sif.src_en = '0;
      sif.dst_addr = '0; sif.dst_en = '0; sif.ret_addr = '0; sif.ret_en = '0;
      sif2.iss_valid = 0; sif2.flush = 0; sif2.src_addr = '0; sif2.src_en = '0;
      sif2.dst_addr = '0; sif2.dst_en = '0; sif2.ret_addr = '0; sif2.ret_en = '0;
      foreach (m_cnt[r]) m_cnt[r] = 0;
      m_err = 0;
      m_infl = 0;
      @(negedge clk);

      // Reset, then RAW on r3 and its release after retire.
      step(0, 0, 1, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 2'b00);
      step(0, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 2'b00);
      step(1, 0, 1, 0, 0, 2'b00, 3, 0, 2'b01, 0, 0, 2'b00);
      check("r3_busy_after_issue", sif.busy[3], 1'b1);
      step(1, 0, 1, 3, 0, 2'b01, 0, 0, 2'b00, 0, 0, 2'b00);
      step(1, 0, 1, 3, 0, 2'b01, 0, 0, 2'b00, 3, 0, 2'b01);
      step(1, 0, 1, 3, 0, 2'b01, 0, 0, 2'b00, 0, 0, 2'b00);

      // Issue and retire to r7 in the same cycle.
      step(1, 0, 1, 0, 0, 2'b00, 7, 0, 2'b01, 0, 0, 2'b00);
      step(1, 0, 1, 0, 0, 2'b00, 7, 0, 2'b01, 0, 7, 2'b10);
      idle();

      // Dual destination to r5, then two single retires.
      step(1, 0, 1, 0, 0, 2'b00, 5, 5, 2'b11, 0, 0, 2'b00);
      idle();
      check("inflight_r5_pair", sif.inflight, 2);
      step(1, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00, 5, 0, 2'b01);
      check("r5_busy_after_first_ret", sif.busy[5], 1'b1);
      step(1, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 5, 2'b10);
      check("r5_idle_after_second_ret", sif.busy[5], 1'b0);

      // Out-of-range addresses on every port.
      step(1, 0, 1, 13, 15, 2'b11, 12, 14, 2'b11, 13, 0, 2'b01);
      idle();

      // Flush with a concurrent issue.
      step(1, 0, 1, 0, 0, 2'b00, 2, 9, 2'b11, 0, 0, 2'b00);
      step(1, 1, 1, 0, 0, 2'b00, 4, 0, 2'b01, 2, 0, 2'b01);
      idle();
      check("inflight_after_flush", sif.inflight, 0);

      // Reset mid-operation with r6 at two.
      step(1, 0, 1, 0, 0, 2'b00, 6, 6, 2'b11, 0, 0, 2'b00);
      idle();
      step(0, 0, 1, 0, 0, 2'b00, 1, 0, 2'b01, 6, 0, 2'b01);
      idle();

      // Random traffic.
      for (int k = 0; k < 400; k++) begin
         step(1, ($urandom_range(0, 19) == 0), $urandom_range(0, 1),
              $urandom_range(0, 15), $urandom_range(0, 15), 2'($urandom_range(0, 3)),
              $urandom_range(0, 15), $urandom_range(0, 15), 2'($urandom_range(0, 3)),
              $urandom_range(0, 15), $urandom_range(0, 15),
              ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'b00);
      end

      // Underflow is sticky across flush, cleared only by reset.
      step(0, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 2'b00);
      step(1, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00, 8, 0, 2'b01);
      check("underflow_sets_ovf", sif.ovf_err, 1'b1);
      step(1, 1, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 2'b00);
      idle();
      step(0, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 2'b00);

      // CW=1 instance: dual issue to r1 saturates at 1 and raises the error.
      rst2 = 1'b0;
      #1;
      check("sat_ready_in_reset", sif2.iss_ready, 1'b0);
      @(posedge clk); #1;
      check("sat_reset_busy", sif2.busy, 3'b000);
      check("sat_reset_ovf", sif2.ovf_err, 1'b0);
      @(negedge clk);
      rst2 = 1'b1;
      sif2.iss_valid = 1'b1;
      sif2.dst_addr  = {2'd1, 2'd1};
      sif2.dst_en    = 2'b11;
      #1;
      check("sat_ready", sif2.iss_ready, 1'b1);
      @(posedge clk); #1;
      check("sat_busy", sif2.busy, 3'b010);
      check("sat_ovf", sif2.ovf_err, 1'b1);
      @(negedge clk);
      sif2.iss_valid = 1'b0;
      sif2.dst_en    = 2'b00;
      @(posedge clk); #1;
      check("sat_inflight", sif2.inflight, 1);
      @(negedge clk);
      sif2.flush = 1'b1;
      #1;
      check("sat_ready_flush", sif2.iss_ready, 1'b0);
      @(posedge clk); #1;
      check("sat_busy_flush", sif2.busy, 3'b000);
      check("sat_ovf_held", sif2.ovf_err, 1'b1);
      @(negedge clk);
      sif2.flush = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
